boot_copier: RTL and testbench
==============================

Name: boot_copier

Overview:
- Sequencer that reads the boot ROM byte by byte (ROM address out, ROM data in) and writes each byte into system RAM starting at DEST_BASE.
- Holds the Z80 in reset until the copy completes, then releases it.
- Sits between the boot ROM, the RAM write arbiter and the CPU reset tree.
- Latches the model selection at start so the ROM image cannot change mid-copy.

Parameters:
- LENGTH, 275: number of bytes copied. Legal range 1..512.
- DEST_BASE, 16'h0000: RAM address of the first byte.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a copy
- model  in  1  system model (0 = 8512, 1 = 9512), sampled on an accepted start
- rom_addr  out  9  ROM byte address (registered)
- rom_model  out  1  latched model driven to the ROM
- rom_data  in  8  ROM byte (combinational from rom_addr/rom_model)
- ram_addr  out  16  RAM write address
- ram_din  out  8  RAM write data
- ram_wr  out  1  write request, held until acknowledged
- ram_ack  in  1  write accepted
- cpu_reset  out  1  CPU reset hold
- busy  out  1  copy in progress
- done  out  1  copy complete

Behaviour:
- Reset values (asynchronous): state=IDLE, count=0, rom_addr=0, rom_model=0, ram_addr=DEST_BASE, ram_din=0, ram_wr=0, cpu_reset=1, busy=0, done=0.
- All outputs are registered.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE, start=1:
  - count<=0, rom_addr<=0, rom_model<=model.
  - busy<=1, cpu_reset<=1.
  - Go to FETCH.
- IDLE, start=0: stay; cpu_reset stays 1.
- FETCH (exactly one cycle; rom_addr=count is stable):
  - ram_din<=rom_data, ram_addr<=DEST_BASE+count (mod 2^16), ram_wr<=1.
  - Go to WRITE.
- WRITE:
  - ram_wr, ram_addr and ram_din are held stable until a cycle in which ram_wr=1 and ram_ack=1. That cycle completes the write.
  - On completion: ram_wr<=0.
    - If count==LENGTH-1: go to DONE, busy<=0, done<=1, cpu_reset<=0.
    - Otherwise: count<=count+1, rom_addr<=count+1, go to FETCH.
  - ram_ack while ram_wr=0 is ignored in every state.
- Throughput: 2 cycles per byte with ram_ack tied high.
  - First ram_wr assertion: 2 cycles after start is sampled.
  - cpu_reset falls 2*LENGTH+1 cycles after start is sampled (zero-wait RAM).
- DONE:
  - done=1, cpu_reset=0, state held indefinitely.
  - start=1 restarts the copy exactly as from IDLE: done<=0, cpu_reset<=1, model re-latched.
- start while busy (FETCH/WRITE) is ignored. The count and the latched model are unaffected.
- model changes while busy have no effect; rom_model changes only on an accepted start.
- Reset mid-copy: all registers return to reset values at once; any pending ram_wr drops asynchronously. After reset deasserts, the block waits in IDLE for start.
- Each address DEST_BASE..DEST_BASE+LENGTH-1 is written exactly once per copy, in ascending order with no gaps. No write is issued outside that range.
- Arithmetic: count is 9 bits. ram_addr is a 16-bit sum that wraps modulo 65536 (e.g. DEST_BASE=16'hFFFF wraps to 0 for the second byte).

Test Plan:
- ram_ack tied high, model=0, start pulse:
  - 275 writes; RAM[0]=C3, RAM[1]=02, RAM[2]=01, RAM[274]=00.
  - cpu_reset falls exactly 551 cycles after start.
  - done=1, busy=0.
- model=1 then start; flip model to 0 at byte 50:
  - rom_model stays 1 throughout.
  - RAM[128] receives the 9512 byte (3D), not 3C.
- ram_ack randomly delayed 0..5 cycles:
  - ram_addr/ram_din stable while ram_wr=1.
  - No duplicated or skipped addresses; final image matches the ROM.
  - Extra ram_ack pulses while ram_wr=0 cause no writes.
- reset asserted mid-copy at byte 100:
  - ram_wr and busy drop immediately; cpu_reset=1.
  - No activity until the next start.
  - The next copy restarts at address 0.
- start pulses during busy, and a start in DONE:
  - Pulses during busy are ignored.
  - The start in DONE re-asserts cpu_reset the next cycle and repeats the full 275-byte copy.
- DEST_BASE=16'hFFFF, LENGTH=3: writes to FFFF, 0000, 0001, then done=1.

Source files
------------

// File: rtl/boot_copier.sv
// Boot ROM to RAM copy sequencer: holds the CPU in reset while LENGTH bytes are
// copied from the boot ROM into RAM starting at DEST_BASE, then releases it.
//   state | meaning
//   IDLE  | waiting for start after reset, CPU held in reset
//   FETCH | rom_addr = count is stable, capture the ROM byte into the write regs
//   WRITE | ram_wr held with stable address/data until acknowledged
//   DONE  | copy finished, CPU released, start re-runs the copy
module boot_copier #(
    parameter int          LENGTH    = 275,
    parameter logic [15:0] DEST_BASE = 16'h0000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        model,
    output logic [8:0]  rom_addr,
    output logic        rom_model,
    input  logic [7:0]  rom_data,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_wr,
    input  logic        ram_ack,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] LAST = 9'(LENGTH - 1);

    state_t      r_state,     w_state;
    logic [8:0]  r_count,     w_count;
    logic [8:0]  r_rom_addr,  w_rom_addr;
    logic        r_rom_model, w_rom_model;
    logic [15:0] r_ram_addr,  w_ram_addr;
    logic [7:0]  r_ram_din,   w_ram_din;
    logic        r_ram_wr,    w_ram_wr;
    logic        r_cpu_reset, w_cpu_reset;
    logic        r_busy,      w_busy;
    logic        r_done,      w_done;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rom_addr  <= '0;
            r_rom_model <= 1'b0;
            r_ram_addr  <= DEST_BASE;
            r_ram_din   <= '0;
            r_ram_wr    <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_count     <= w_count;
            r_rom_addr  <= w_rom_addr;
            r_rom_model <= w_rom_model;
            r_ram_addr  <= w_ram_addr;
            r_ram_din   <= w_ram_din;
            r_ram_wr    <= w_ram_wr;
            r_cpu_reset <= w_cpu_reset;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_count     = r_count;
        w_rom_addr  = r_rom_addr;
        w_rom_model = r_rom_model;
        w_ram_addr  = r_ram_addr;
        w_ram_din   = r_ram_din;
        w_ram_wr    = r_ram_wr;
        w_cpu_reset = r_cpu_reset;
        w_busy      = r_busy;
        w_done      = r_done;
        case (r_state)
            IDLE, DONE: begin
                // model is latched only here so the ROM image cannot change mid-copy
                if (start) begin
                    w_count     = '0;
                    w_rom_addr  = '0;
                    w_rom_model = model;
                    w_busy      = 1'b1;
                    w_cpu_reset = 1'b1;
                    w_done      = 1'b0;
                    w_state     = FETCH;
                end
            end
            FETCH: begin
                w_ram_din  = rom_data;
                w_ram_addr = DEST_BASE + {7'b0, r_count};
                w_ram_wr   = 1'b1;
                w_state    = WRITE;
            end
            WRITE: begin
                if (r_ram_wr && ram_ack) begin
                    w_ram_wr = 1'b0;
                    if (r_count == LAST) begin
                        w_busy      = 1'b0;
                        w_done      = 1'b1;
                        w_cpu_reset = 1'b0;
                        w_state     = DONE;
                    end else begin
                        w_count    = r_count + 9'd1;
                        w_rom_addr = r_count + 9'd1;
                        w_state    = FETCH;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign rom_addr  = r_rom_addr;
    assign rom_model = r_rom_model;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_wr    = r_ram_wr;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_boot_copier.sv
// Bench for boot_copier: cycle vector table for the copy start-up, then full
// copies with tied, random and manual RAM acknowledge plus a wrapping instance.
module tb_boot_copier;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        start, model;
    logic [8:0]  rom_addr;
    logic        rom_model;
    logic [7:0]  rom_data;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wr, ram_ack, cpu_reset, busy, done;

    logic        u2_start, u2_model;
    logic [8:0]  u2_rom_addr;
    logic        u2_rom_model;
    logic [7:0]  u2_rom_data;
    logic [15:0] u2_ram_addr;
    logic [7:0]  u2_ram_din;
    logic        u2_ram_wr, u2_cpu_reset, u2_busy, u2_done;

    int n_vec  = 0;
    int n_miss = 0;

    int   ack_mode = 2;   // 0 tied high, 1 random delay, 2 manual
    logic man_ack  = 1'b0;
    logic gen_ack  = 1'b0;
    int   wait_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] rom_byte(input logic m, input logic [8:0] a);
        logic [7:0] d;
        case (a)
            9'd0:    d = 8'hC3;
            9'd1:    d = 8'h02;
            9'd2:    d = 8'h01;
            9'd128:  d = m ? 8'h3D : 8'h3C;
            9'd274:  d = 8'h00;
            default: begin
                d = a[7:0] + {a[8], 7'h25};
                if (m) d = d ^ 8'h5A;
            end
        endcase
        return d;
    endfunction

    assign rom_data    = rom_byte(rom_model, rom_addr);
    assign u2_rom_data = rom_byte(u2_rom_model, u2_rom_addr);
    assign ram_ack     = (ack_mode == 2) ? man_ack : gen_ack;

    boot_copier dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .model(model),
        .rom_addr(rom_addr), .rom_model(rom_model), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr(ram_wr), .ram_ack(ram_ack),
        .cpu_reset(cpu_reset), .busy(busy), .done(done)
    );

    boot_copier #(.LENGTH(3), .DEST_BASE(16'hFFFF)) u2 (
        .clk_sys(clk_sys), .reset(reset), .start(u2_start), .model(u2_model),
        .rom_addr(u2_rom_addr), .rom_model(u2_rom_model), .rom_data(u2_rom_data),
        .ram_addr(u2_ram_addr), .ram_din(u2_ram_din), .ram_wr(u2_ram_wr), .ram_ack(1'b1),
        .cpu_reset(u2_cpu_reset), .busy(u2_busy), .done(u2_done)
    );

    always @(negedge clk_sys) begin
        if (ack_mode == 0) begin
            gen_ack = 1'b1;
        end else if (ram_wr) begin
            if (wait_cnt == 0) gen_ack = 1'b1;
            else begin
                gen_ack  = 1'b0;
                wait_cnt = wait_cnt - 1;
            end
        end else begin
            // stray acks while no write is pending must be ignored
            gen_ack  = ($urandom_range(0, 2) == 0);
            wait_cnt = $urandom_range(0, 5);
        end
    end

    // RAM model and write scoreboard for the default instance
    logic [7:0]  mem [0:511];
    int          mon_idx = 0, wcount = 0, wr_bad = 0, stab_bad = 0;
    logic        sb_model = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] h_addr;
    logic [7:0]  h_din;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mon_idx = 0;
            wcount  = 0;
            hold    = 1'b0;
        end else begin
            if (start && !busy) begin
                mon_idx  = 0;
                wcount   = 0;
                sb_model = model;
            end
            if (hold && (ram_addr !== h_addr || ram_din !== h_din)) stab_bad++;
            if (ram_wr && ram_ack) begin
                if (mon_idx >= 275 || ram_addr !== 16'(mon_idx) ||
                    ram_din !== rom_byte(sb_model, 9'(mon_idx)))
                    wr_bad++;
                if (mon_idx < 512) mem[mon_idx] = ram_din;
                mon_idx++;
                wcount++;
                hold = 1'b0;
            end else if (ram_wr) begin
                hold   = 1'b1;
                h_addr = ram_addr;
                h_din  = ram_din;
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_image(input logic m);
        int bad = 0;
        for (int i = 0; i < 275; i++)
            if (mem[i] !== rom_byte(m, 9'(i))) bad++;
        check("image_bytes_wrong", bad, 0);
    endtask

    int rm_bad;

    task automatic run_copy(input logic m, input int mode, input bit flip,
                            input bit pokes, input int stop_at, output int n);
        bit poke;
        ack_mode = mode;
        rm_bad   = 0;
        @(negedge clk_sys);
        start = 1'b1;
        model = m;
        n     = 0;
        while (n < 4000) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (n == 1) begin
                check("start_cpu_reset", cpu_reset, 1);
                check("start_busy", busy, 1);
                check("start_done", done, 0);
            end
            poke  = pokes && (n % 97 == 0);
            start = poke;
            model = (poke || (flip && mon_idx >= 50)) ? ~m : m;
            if (rom_model !== m) rm_bad++;
            if (stop_at >= 0 && mon_idx >= stop_at && ram_wr) break;
            if (!cpu_reset) break;
        end
        start = 1'b0;
        check("rom_model_held", rm_bad, 0);
        if (stop_at < 0) check("copy_finished_cpu_reset", cpu_reset, 0);
    endtask

    task automatic check_finished(input logic m);
        check("done_flag", done, 1);
        check("busy_flag", busy, 0);
        check("write_count", wcount, 275);
        check("write_order_data", wr_bad, 0);
        check("ram0", mem[0], 8'hC3);
        check("ram1", mem[1], 8'h02);
        check("ram2", mem[2], 8'h01);
        check("ram274", mem[274], 8'h00);
        check_image(m);
    endtask

    typedef struct {
        logic        s, m, a;
        logic        busy, wr, cpu, done, rmod;
        logic [8:0]  raddr;
        logic [15:0] waddr;
        logic [7:0]  din;
    } vec_t;

    vec_t vt [9];

    initial begin
        int n, na, bad;
        logic [15:0] u2_addrs [3];
        logic [7:0]  u2_dins  [3];

        //           s     m     a     busy  wr    cpu   done  rmod  raddr  waddr     din
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 16'h0000, 8'h00};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 16'h0000, 8'h00};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'd0, 16'h0000, 8'hC3};
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'd0, 16'h0000, 8'hC3};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'd0, 16'h0000, 8'hC3};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'd1, 16'h0000, 8'hC3};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'd1, 16'h0001, 8'h02};
        vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'd2, 16'h0001, 8'h02};
        vt[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'd2, 16'h0002, 8'h01};

        reset = 1'b1; start = 1'b0; model = 1'b0;
        u2_start = 1'b0; u2_model = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_model", rom_model, 0);
        check("rst_ram_addr", ram_addr, 16'h0000);
        check("rst_ram_din", ram_din, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_u2_ram_addr", u2_ram_addr, 16'hFFFF);
        @(negedge clk_sys);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk_sys);
            start = vt[i].s; model = vt[i].m; man_ack = vt[i].a;
            @(posedge clk_sys);
            #1;
            bad = 0;
            if (busy !== vt[i].busy || ram_wr !== vt[i].wr || cpu_reset !== vt[i].cpu ||
                done !== vt[i].done || rom_model !== vt[i].rmod || rom_addr !== vt[i].raddr ||
                ram_addr !== vt[i].waddr || ram_din !== vt[i].din) bad = 1;
            n_vec++;
            if (bad != 0) begin
                n_miss++;
                $display("FAIL table vector %0d: got busy=%b wr=%b cpu=%b done=%b rmod=%b raddr=%0h waddr=%h din=%h, expected busy=%b wr=%b cpu=%b done=%b rmod=%b raddr=%0h waddr=%h din=%h",
                         i, busy, ram_wr, cpu_reset, done, rom_model, rom_addr, ram_addr, ram_din,
                         vt[i].busy, vt[i].wr, vt[i].cpu, vt[i].done, vt[i].rmod, vt[i].raddr,
                         vt[i].waddr, vt[i].din);
            end
        end
        @(negedge clk_sys);
        start = 1'b0; man_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;

        // zero-wait copy, model 8512
        run_copy(1'b0, 0, 1'b0, 1'b0, -1, n);
        check("cpu_reset_latency", n, 551);
        check_finished(1'b0);
        repeat (5) @(posedge clk_sys);
        #1;
        check("done_held", done, 1);
        check("done_cpu_released", cpu_reset, 0);
        check("done_no_write", ram_wr, 0);

        // model 9512 latched, live model flips mid-copy
        run_copy(1'b1, 0, 1'b1, 1'b0, -1, n);
        check_finished(1'b1);
        check("ram128_9512", mem[128], 8'h3D);
        check("rom_model_after", rom_model, 1);

        // random acknowledge latency with stray acks
        run_copy(1'b0, 1, 1'b0, 1'b0, -1, n);
        check_finished(1'b0);
        check("write_held_stable", stab_bad, 0);

        // reset in the middle of a pending write
        run_copy(1'b0, 0, 1'b0, 1'b0, 100, n);
        check("pre_reset_pending_wr", ram_wr, 1);
        reset = 1'b1;
        #1;
        check("midreset_ram_wr", ram_wr, 0);
        check("midreset_busy", busy, 0);
        check("midreset_cpu_reset", cpu_reset, 1);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk_sys);
            #1;
            if (ram_wr !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b1) bad++;
        end
        check("idle_after_reset_activity", bad, 0);
        check("idle_after_reset_writes", wcount, 0);
        run_copy(1'b0, 0, 1'b0, 1'b0, -1, n);
        check("copy_after_reset_latency", n, 551);
        check_finished(1'b0);

        // restart from DONE with start pulses (and model flips) during busy
        run_copy(1'b1, 0, 1'b0, 1'b1, -1, n);
        check("restart_latency", n, 551);
        check_finished(1'b1);
        check("restart_ram128", mem[128], 8'h3D);

        // wrapping destination, three bytes
        @(negedge clk_sys);
        u2_start = 1'b1;
        u2_model = 1'b0;
        n = 0; na = 0;
        while (n < 40) begin
            @(posedge clk_sys);
            #1;
            n++;
            u2_start = 1'b0;
            if (u2_ram_wr) begin
                if (na < 3) begin
                    u2_addrs[na] = u2_ram_addr;
                    u2_dins[na]  = u2_ram_din;
                end
                na++;
            end
            if (!u2_cpu_reset) break;
        end
        check("wrap_write_count", na, 3);
        check("wrap_addr0", u2_addrs[0], 16'hFFFF);
        check("wrap_addr1", u2_addrs[1], 16'h0000);
        check("wrap_addr2", u2_addrs[2], 16'h0001);
        check("wrap_din0", u2_dins[0], 8'hC3);
        check("wrap_din2", u2_dins[2], 8'h01);
        check("wrap_latency", n, 7);
        check("wrap_done", u2_done, 1);
        check("wrap_busy", u2_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
